alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares the single registered ALU between two requesters:
  - Requester 0 is the execute stage.
  - Requester 1 is the address/branch-compare unit.
- Fully pipelined: one new operation per cycle and a fixed issue-to-response latency equal to the ALU's register depth.
- Issue is granted round-robin.
- Each result is routed back to the requester that issued it using an internal tag pipeline.

## Interface

Parameters:
- ALU_LATENCY, 1, cycles from operand presentation to valid `alu_result`/`alu_zero`; legal range 1–4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- stall  input  1  pipeline freeze; blocks new grants while high.
- req0_valid  input  1  requester 0 has an operation.
- req0_op  input  4  requester 0 ALU opcode.
- req0_a  input  32  requester 0 operand A.
- req0_b  input  32  requester 0 operand B.
- req0_ready  output  1  requester 0 granted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- alu_op  output  4  opcode to ALU.
- alu_a  output  32  operand A to ALU.
- alu_b  output  32  operand B to ALU.
- alu_result  input  32  ALU result.
- alu_zero  input  1  ALU zero flag.
- resp0_valid  output  1  response for requester 0 present.
- resp1_valid  output  1  response for requester 1 present.
- resp_result  output  32  shared result bus, equal to `alu_result`.
- resp_zero  output  1  shared zero flag, equal to `alu_zero`.

## Operation

Handshake and grant:
- A transfer occurs on requester i in any cycle where `reqi_valid && reqi_ready`.
- `reqi_ready` is combinational and is never asserted without `reqi_valid`.
- `stall`=1 forces both ready signals to 0.
- At most one ready signal is high per cycle.

Arbitration:
- A 1-bit register `last` holds the most recent grant.
- If only one requester is valid, it is granted.
- If both are valid, the requester not equal to `last` is granted.
- `last` updates only on a transfer.
- Reset value of `last` = 1, so requester 0 wins the first contention.

ALU drive:
- `alu_op`, `alu_a`, `alu_b` are combinationally muxed from the granted requester.
- With no grant they are driven to 0 (opcode 0, operands 0); the resulting ALU output is ignored.

Tag pipeline:
- Shift register of ALU_LATENCY stages, each holding {valid, id}.
- Stage 0 loads {transfer, granted id} every cycle, including during `stall`.
- All stages shift every cycle; the pipeline never stalls, because the ALU does not stall.

Response:
- When the last stage is valid, `resp<id>_valid`=1; otherwise both are 0.
- `resp_result`/`resp_zero` pass `alu_result`/`alu_zero` through unregistered.
- Requesters must accept a response in the cycle it appears; there is no backpressure.
- Requesters may keep `valid` high across cycles. A request is held unchanged until granted; the arbiter relies on this but does not check it.

## Timing

Reset:
- Asynchronous assert: all tag stages invalid, `last`=1.
- With `rst` low: `resp0_valid`=`resp1_valid`=0 and both ready=0 (ready gated by `rst`). `alu_op`=0, `alu_a`=`alu_b`=0.
- The reset release edge is synchronised externally; the first grant can occur in the first cycle with `rst` high.

Latency and throughput:
- A transfer in cycle N gives `resp<id>_valid`=1 in cycle N+ALU_LATENCY, for exactly one cycle.
- Throughput is one transfer per cycle.
- Back-to-back transfers produce back-to-back responses in issue order.
- With both requesters continuously valid, grants alternate 0,1,0,1…

Boundary conditions:
- `stall` rising mid-stream: issue stops in the same cycle; in-flight responses still emerge on schedule.
- `stall` falling: grants resume in the same cycle, and round-robin continues from `last`.
- Reset mid-operation: in-flight tags are discarded and no response is produced for them, even though the ALU may still output results.
- Simultaneous response and new grant for the same requester: both are allowed.
- ALU_LATENCY outside 1–4: elaboration error.

## Test plan

- Reset, then `req0_valid`=1 with op=0, a=5, b=7, ALU_LATENCY=1 -> `req0_ready`=1 in cycle 0; `resp0_valid`=1 with `resp_result`=12 in cycle 1; `resp1_valid`=0 throughout.
- Both requesters valid for 4 cycles (req0 a=1,b=1; req1 a=10,b=10) -> grants 0,1,0,1; responses resp0 2, resp1 20, resp0 2, resp1 20 on consecutive cycles.
- ALU_LATENCY=3, req1 issues a=0xFFFFFFFF, b=1 -> `resp1_valid` exactly 3 cycles later with `resp_result`=0 and `resp_zero`=1.
- Issue from req0, then assert `stall` for 2 cycles with req1 valid -> the in-flight req0 response still arrives; `req1_ready`=0 during stall; req1 is granted in the first cycle after `stall` falls.
- Two transfers in flight (ALU_LATENCY=2), assert `rst` low asynchronously mid-cycle -> `resp*_valid` drops immediately; no response after release; the next contention grants requester 0.
- Only req1 valid for 3 cycles, then both valid -> req1 granted 3 times, then req0 wins the contention (`last`=1).

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one fully pipelined, registered ALU between two requesters.
//   Requester 0 is the execute stage and requester 1 is the address/branch-compare unit.
//   Issue is round-robin. A tag pipeline that is ALU_LATENCY deep routes each result
//   back to the requester that issued it.
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   stall                      blocks new grants while high
//   req{0,1}_valid/op/a/b      request from each requester
//   req{0,1}_ready             combinational grant for this cycle
//   alu_op/a/b                 operands to the ALU; zero when nothing is granted
//   alu_result/alu_zero        ALU output, ALU_LATENCY cycles after the operands
//   resp{0,1}_valid            response strobe for the owning requester
//   resp_result/resp_zero      shared pass-through of the ALU output
module alu_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_result,
  output logic        resp_zero
);

  generate
    if (ALU_LATENCY < 1 || ALU_LATENCY > 4) begin : g_bad_latency
      $error("alu_arbiter: ALU_LATENCY must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  tag_t [ALU_LATENCY-1:0] tag_q, tag_d;
  logic last_q, last_d;
  logic cand0, cand1, gnt0, gnt1, xfer;

  always_comb begin
    // Ready is gated by reset as well as by stall, so nothing issues while rst is low.
    cand0 = rst & ~stall & req0_valid;
    cand1 = rst & ~stall & req1_valid;
    // On contention, grant the requester that did not win last time.
    gnt0  = cand0 & (~cand1 | last_q);
    gnt1  = cand1 & (~cand0 | ~last_q);
    xfer  = gnt0 | gnt1;
    last_d = xfer ? gnt1 : last_q;

    // The tag pipe shifts every cycle, including during stall, because the ALU never stalls.
    tag_d = tag_q;
    tag_d[0].vld = xfer;
    tag_d[0].id  = gnt1;
    for (int i = 1; i < ALU_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      last_q <= 1'b1;
    end else begin
      tag_q  <= tag_d;
      last_q <= last_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (gnt0) begin
      alu_op = req0_op;
      alu_a  = req0_a;
      alu_b  = req0_b;
    end else if (gnt1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  assign resp0_valid = tag_q[ALU_LATENCY-1].vld & ~tag_q[ALU_LATENCY-1].id;
  assign resp1_valid = tag_q[ALU_LATENCY-1].vld &  tag_q[ALU_LATENCY-1].id;
  assign resp_result = alu_result;
  assign resp_zero   = alu_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. Three instances with ALU_LATENCY of 1, 2 and 3 share one
// set of request inputs. Each instance drives its own behavioural ALU of matching depth.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  // Per-instance outputs; index 0 is latency 1, index 1 is latency 2, index 2 is latency 3.
  logic [2:0]       rdy0, rdy1, r0v, r1v, rzero, azero;
  logic [3:0]       aop [3];
  logic [31:0]      aa [3], ab [3], ares [3], rres [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural registered ALUs of depth 1, 2 and 3. They are never reset.
  logic [31:0] p1, p2 [2], p3 [3];
  always @(posedge clk) begin
    p1    <= alu_f(aop[0], aa[0], ab[0]);
    p2[0] <= alu_f(aop[1], aa[1], ab[1]);
    p2[1] <= p2[0];
    p3[0] <= alu_f(aop[2], aa[2], ab[2]);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ares[0] = p1;
  assign ares[1] = p2[1];
  assign ares[2] = p3[2];
  assign azero[0] = (p1 == 32'd0);
  assign azero[1] = (p2[1] == 32'd0);
  assign azero[2] = (p3[2] == 32'd0);

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_arbiter #(.ALU_LATENCY(g + 1)) u_dut (
      .clk(clk), .rst(rst), .stall(stall),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rdy0[g]),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rdy1[g]),
      .alu_op(aop[g]), .alu_a(aa[g]), .alu_b(ab[g]),
      .alu_result(ares[g]), .alu_zero(azero[g]),
      .resp0_valid(r0v[g]), .resp1_valid(r1v[g]),
      .resp_result(rres[g]), .resp_zero(rzero[g])
    );
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        rst, stall;
    logic        v0;
    logic [3:0]  op0;
    logic [31:0] a0, b0;
    logic        v1;
    logic [3:0]  op1;
    logic [31:0] a1, b1;
    logic        e_rdy0, e_rdy1, e_r0, e_r1;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_a;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic s,
    input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
    input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
    input logic er0y, input logic er1y, input logic e0, input logic e1,
    input logic [31:0] eres, input logic ez, input logic [31:0] ea);
    vec_t t;
    t.rst = r; t.stall = s;
    t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0;
    t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1;
    t.e_rdy0 = er0y; t.e_rdy1 = er1y; t.e_r0 = e0; t.e_r1 = e1;
    t.e_res = eres; t.e_zero = ez; t.e_a = ea;
    return t;
  endfunction

  task automatic drive(input logic r, input logic s,
                       input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    rst = r; stall = s;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
  endtask

  // Go to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    drive(r, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  vec_t tbl [25];

  initial begin
    // Expected values for the latency-1 instance, computed by hand.
    //           rst  stl v0 op  a0     b0     v1 op  a1      b1     rdy0 rdy1 r0 r1 result      zero a
    tbl[0]  = mk(0,0, 1,0,32'd5,32'd7,  1,0,32'd10,32'd10, 0,0,0,0, 32'd0,    0, 32'd0);
    tbl[1]  = mk(1,0, 1,0,32'd5,32'd7,  0,0,32'd0,32'd0,   1,0,0,0, 32'd0,    0, 32'd5);
    tbl[2]  = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,1,0, 32'd12,   0, 32'd0);
    tbl[3]  = mk(0,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,0, 32'd0,    0, 32'd0);
    tbl[4]  = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd10,32'd10, 1,0,0,0, 32'd0,    0, 32'd1);
    tbl[5]  = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd10,32'd10, 0,1,1,0, 32'd2,    0, 32'd10);
    tbl[6]  = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd10,32'd10, 1,0,0,1, 32'd20,   0, 32'd1);
    tbl[7]  = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd10,32'd10, 0,1,1,0, 32'd2,    0, 32'd10);
    tbl[8]  = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,1, 32'd20,   0, 32'd0);
    tbl[9]  = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,0, 32'd0,    0, 32'd0);
    tbl[10] = mk(1,0, 1,0,32'd3,32'd4,  0,0,32'd0,32'd0,   1,0,0,0, 32'd0,    0, 32'd3);
    tbl[11] = mk(1,1, 0,0,32'd0,32'd0,  1,0,32'd10,32'd10, 0,0,1,0, 32'd7,    0, 32'd0);
    tbl[12] = mk(1,1, 0,0,32'd0,32'd0,  1,0,32'd10,32'd10, 0,0,0,0, 32'd0,    0, 32'd0);
    tbl[13] = mk(1,0, 0,0,32'd0,32'd0,  1,0,32'd10,32'd10, 0,1,0,0, 32'd0,    0, 32'd10);
    tbl[14] = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,1, 32'd20,   0, 32'd0);
    tbl[15] = mk(1,0, 0,0,32'd0,32'd0,  1,0,32'd2,32'd3,   0,1,0,0, 32'd0,    0, 32'd2);
    tbl[16] = mk(1,0, 0,0,32'd0,32'd0,  1,0,32'd2,32'd3,   0,1,0,1, 32'd5,    0, 32'd2);
    tbl[17] = mk(1,0, 0,0,32'd0,32'd0,  1,0,32'd2,32'd3,   0,1,0,1, 32'd5,    0, 32'd2);
    tbl[18] = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd2,32'd3,   1,0,0,1, 32'd5,    0, 32'd1);
    tbl[19] = mk(1,0, 1,0,32'd1,32'd1,  1,0,32'd2,32'd3,   0,1,1,0, 32'd2,    0, 32'd2);
    tbl[20] = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,1, 32'd5,    0, 32'd0);
    tbl[21] = mk(1,0, 1,1,32'd5,32'd5,  0,0,32'd0,32'd0,   1,0,0,0, 32'd0,    0, 32'd5);
    tbl[22] = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,1,0, 32'd0,    1, 32'd0);
    tbl[23] = mk(1,0, 0,0,32'd0,32'd0,  1,2,32'hF0,32'h3C, 0,1,0,0, 32'd0,    0, 32'hF0);
    tbl[24] = mk(1,0, 0,0,32'd0,32'd0,  0,0,32'd0,32'd0,   0,0,0,1, 32'h30,   0, 32'd0);

    idle(1'b0);
    next_cycle();

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
            tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1);
      #3;
      chk($sformatf("row%0d rdy0", i), {31'd0, rdy0[0]}, {31'd0, tbl[i].e_rdy0});
      chk($sformatf("row%0d rdy1", i), {31'd0, rdy1[0]}, {31'd0, tbl[i].e_rdy1});
      chk($sformatf("row%0d resp0", i), {31'd0, r0v[0]}, {31'd0, tbl[i].e_r0});
      chk($sformatf("row%0d resp1", i), {31'd0, r1v[0]}, {31'd0, tbl[i].e_r1});
      chk($sformatf("row%0d alu_a", i), aa[0], tbl[i].e_a);
      if (tbl[i].e_r0 || tbl[i].e_r1) begin
        chk($sformatf("row%0d result", i), rres[0], tbl[i].e_res);
        chk($sformatf("row%0d zero", i), {31'd0, rzero[0]}, {31'd0, tbl[i].e_zero});
      end
      next_cycle();
    end

    // Latency 3: all-ones + 1 wraps to zero, and the response appears exactly 3 cycles later.
    idle(1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
    #3 chk("lat3 rdy1", {31'd0, rdy1[2]}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      idle(1'b1);
      #3;
      chk($sformatf("lat3 resp1 +%0d", k), {31'd0, r1v[2]}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat3 resp0 +%0d", k), {31'd0, r0v[2]}, 32'd0);
      if (k == 3) begin
        chk("lat3 result", rres[2], 32'd0);
        chk("lat3 zero", {31'd0, rzero[2]}, 32'd1);
      end
    end

    // Latency 2: assert reset in the middle of a cycle with two transfers in flight.
    next_cycle();
    idle(1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
    #3 chk("lat2 rdy0", {31'd0, rdy0[1]}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd3, 32'd4);
    #3 chk("lat2 rdy1", {31'd0, rdy1[1]}, 32'd1);
    next_cycle();
    idle(1'b1);
    #3;
    chk("lat2 resp0 before rst", {31'd0, r0v[1]}, 32'd1);
    chk("lat2 result before rst", rres[1], 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("lat2 resp0 in rst", {31'd0, r0v[1]}, 32'd0);
    chk("lat2 resp1 in rst", {31'd0, r1v[1]}, 32'd0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk($sformatf("lat2 post-rst resp0 %0d", k), {31'd0, r0v[1]}, 32'd0);
      chk($sformatf("lat2 post-rst resp1 %0d", k), {31'd0, r1v[1]}, 32'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd2, 32'd2);
    #3;
    chk("lat2 post-rst rdy0", {31'd0, rdy0[1]}, 32'd1);
    chk("lat2 post-rst rdy1", {31'd0, rdy1[1]}, 32'd0);
    next_cycle();
    idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
